// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_sel encoding, divisor calculation and receiver FSM states.
package uart_pkg;

   localparam logic [2:0] BAUD_9600   = 3'b000;
   localparam logic [2:0] BAUD_19200  = 3'b001;
   localparam logic [2:0] BAUD_38400  = 3'b010;
   localparam logic [2:0] BAUD_57600  = 3'b011;
   localparam logic [2:0] BAUD_115200 = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_e;

   function automatic int unsigned baud_rate(logic [2:0] sel);
      case (sel)
         BAUD_9600:  return 9600;
         BAUD_19200: return 19200;
         BAUD_38400: return 38400;
         BAUD_57600: return 57600;
         default:    return 115200;
      endcase
   endfunction

   // Rounded to nearest: DIV = round(clk_hz / (oversample * baud)).
   function automatic int unsigned baud_div(int unsigned clk_hz, int unsigned oversample,
                                            logic [2:0] sel);
      int unsigned den;
      den = oversample * baud_rate(sel);
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divisor counter: emits a one-cycle tick every div_i clocks; clr_i restarts the period.
module uart_baud_tick #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic [W-1:0] div_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q;

   assign tick_o = (cnt_q == div_i - W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + W'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled centre sampling and a one-entry valid/ready output.
import uart_pkg::*;

module uart_rx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [2:0] baud_sel,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned SW   = $clog2(OVERSAMPLE);
   localparam int unsigned DIV0 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_9600);
   localparam int unsigned DIV1 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_19200);
   localparam int unsigned DIV2 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_38400);
   localparam int unsigned DIV3 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_57600);
   localparam int unsigned DIV4 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_115200);

   rx_state_e    state_q;
   logic [2:0]   sel_q;
   logic         sync1_q, sync2_q, prev_q;
   logic [1:0]   fill_q;
   logic         armed_q;
   logic [SW-1:0] samp_q;
   logic [2:0]   bit_q;
   logic [7:0]   shift_q;
   logic [7:0]   rx_data_q;
   logic         rx_valid_q, frame_err_q, overrun_q, busy_q;

   logic [15:0]  div_d;
   logic         fall_d, clr_d, tick, sample_d, deliver_d;

   always_comb begin
      div_d = 16'(DIV4);
      case (sel_q)
         BAUD_9600:  div_d = 16'(DIV0);
         BAUD_19200: div_d = 16'(DIV1);
         BAUD_38400: div_d = 16'(DIV2);
         BAUD_57600: div_d = 16'(DIV3);
         default:    div_d = 16'(DIV4);
      endcase
   end

   // armed_q blocks edges until the synchronizer holds a genuine high sample after reset,
   // so a line that is already low at release is not taken as a start edge.
   assign fall_d   = armed_q && prev_q && !sync2_q;
   assign clr_d    = (state_q == ST_IDLE) && fall_d;
   assign sample_d = tick &&
                     (((state_q == ST_START) && (samp_q == SW'(OVERSAMPLE / 2 - 1))) ||
                      (((state_q == ST_DATA) || (state_q == ST_STOP)) &&
                       (samp_q == SW'(OVERSAMPLE - 1))));
   assign deliver_d = sample_d && (state_q == ST_STOP) && sync2_q;

   uart_baud_tick #(.W(16)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr_d),
      .div_i  (div_d),
      .tick_o (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= 3'b000;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         fill_q      <= '0;
         armed_q     <= 1'b0;
         samp_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= rx;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if ((fill_q == 2'd2) && sync2_q) armed_q <= 1'b1;
         if (tick) samp_q <= sample_d ? '0 : samp_q + 1'b1;

         if (deliver_d) begin
            if (!rx_valid_q || rx_ready) begin
               rx_data_q  <= shift_q;
               rx_valid_q <= 1'b1;
            end else begin
               overrun_q  <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (fall_d) begin
                  state_q <= ST_START;
                  sel_q   <= baud_sel;
                  samp_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (sample_d) begin
                  if (sync2_q) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                     bit_q   <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (sample_d) begin
                  shift_q <= {sync2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (sample_d) begin
                  if (sync2_q) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (sync2_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level line model at the 50 MHz clock, hand-computed expectations.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst, rx, rx_ready;
   logic [2:0] baud_sel;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   localparam int BIT_19200  = 163 * 16;
   localparam int BIT_38400  = 81 * 16;
   localparam int BIT_57600  = 54 * 16;
   localparam int BIT_115200 = 27 * 16;

   int checks = 0, errors = 0;
   int cyc = 0, start_cyc = 0, rise_cyc = 0, rise_cnt = 0;
   int fe_cnt = 0, ov_cnt = 0, drop_cnt = 0, run_len = 0, last_run = 0;
   logic mv0, mr0, mrs0;

   always #10 clk = ~clk;

   uart_rx #(.CLK_HZ(50_000_000), .OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .baud_sel  (baud_sel),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always @(posedge clk) begin
      cyc++;
      mv0 = rx_valid; mr0 = rx_ready; mrs0 = rst;
      #1;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (rx_valid === 1'b1 && mv0 !== 1'b1) begin rise_cyc = cyc; rise_cnt++; end
      if (mv0 === 1'b1 && mr0 !== 1'b1 && mrs0 !== 1'b1 && rx_valid !== 1'b1) drop_cnt++;
      if (rx_valid === 1'b1) run_len++;
      else if (run_len != 0) begin last_run = run_len; run_len = 0; end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal;
   end

   task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop);
      @(posedge clk); #1;
      start_cyc = cyc;
      rx = 1'b0;
      repeat (bclk) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = d[i];
         repeat (bclk) @(posedge clk);
      end
      #1 rx = stop;
      repeat (bclk) @(posedge clk);
   endtask

   task automatic wait_rise(input int prev, input string name);
      int n = 0;
      while (rise_cnt == prev && n < 30000) begin @(posedge clk); #2; n++; end
      checks++;
      if (rise_cnt == prev) begin errors++; $display("FAIL %s rx_valid never rose", name); end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; baud_sel = 3'b000;
      repeat (3) @(posedge clk); #2;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", frame_err, overrun); end
      rst = 1'b0;
      repeat (20) @(posedge clk); #1;
   endtask

   task automatic test_timing_55();
      int prev = rise_cnt, fe0 = fe_cnt, ov0 = ov_cnt, dt;
      baud_sel = 3'b001; last_run = 0;
      send_frame(8'h55, BIT_19200, 1'b1);
      wait_rise(prev, "rise55");
      dt = rise_cyc - start_cyc;
      checks++; if (dt < 24776 || dt > 24782) begin errors++; $display("FAIL lat55 got %0d exp 24779+-3", dt); end
      checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL data55 got %h exp 55", rx_data); end
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL flags55 got fe%0d ov%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); end
      checks++; if (last_run != 1) begin errors++; $display("FAIL hold55 got %0d cycles exp 1", last_run); end
   endtask

   task automatic test_baud_change();
      int prev = rise_cnt, fe0 = fe_cnt, ov0 = ov_cnt, dt;
      baud_sel = 3'b010;
      send_frame(8'hAA, BIT_38400, 1'b1);
      wait_rise(prev, "riseAA");
      checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL dataAA got %h exp AA", rx_data); end
      baud_sel = 3'b011;
      fork
         send_frame(8'hEF, BIT_57600, 1'b1);
         begin repeat (4 * BIT_57600) @(posedge clk); #1 baud_sel = 3'b000; end
      join
      wait_rise(prev + 1, "riseEF");
      dt = rise_cyc - start_cyc;
      checks++; if (rx_data !== 8'hEF) begin errors++; $display("FAIL dataEF got %h exp EF", rx_data); end
      checks++; if (dt < 8208 || dt > 8214) begin errors++; $display("FAIL latEF got %0d exp 8211+-3", dt); end
      checks++; if (rise_cnt - prev != 2 || fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL cntAAEF got rise%0d fe%0d ov%0d exp 2 0 0", rise_cnt - prev, fe_cnt - fe0, ov_cnt - ov0); end
   endtask

   task automatic test_frame_err();
      int prev = rise_cnt, fe0 = fe_cnt;
      baud_sel = 3'b100;
      send_frame(8'h3C, BIT_115200, 1'b0);
      checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe3C got %0d pulses exp 1", fe_cnt - fe0); end
      checks++; if (rx_valid !== 1'b0 || rise_cnt != prev) begin errors++; $display("FAIL valid3C got %b exp 0", rx_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_break got %b exp 1", busy); end
      repeat (3 * 10 * BIT_115200) @(posedge clk);
      #1 rx = 1'b1;
      repeat (BIT_115200) @(posedge clk); #2;
      checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_break got %0d pulses exp 1", fe_cnt - fe0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_break got %b exp 0", busy); end
      send_frame(8'h81, BIT_115200, 1'b1);
      wait_rise(prev, "rise81");
      checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL data81 got %h exp 81", rx_data); end
   endtask

   task automatic test_glitch();
      int prev = rise_cnt, fe0 = fe_cnt, ov0 = ov_cnt;
      baud_sel = 3'b100;
      @(posedge clk); #1 rx = 1'b0;
      repeat (10) @(posedge clk); #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b exp 1", busy); end
      repeat (98) @(posedge clk); #1 rx = 1'b1;
      repeat (2 * BIT_115200) @(posedge clk); #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0", busy); end
      checks++; if (rx_valid !== 1'b0 || rise_cnt != prev) begin errors++; $display("FAIL glitch_valid got %b exp 0", rx_valid); end
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL glitch_flags got fe%0d ov%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); end
   endtask

   task automatic test_overrun();
      int ov0 = ov_cnt;
      baud_sel = 3'b100; rx_ready = 1'b0;
      send_frame(8'h11, BIT_115200, 1'b1);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ov_first got %b/%h exp 1/11", rx_valid, rx_data); end
      send_frame(8'h22, BIT_115200, 1'b1);
      checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ov_pulse got %0d exp 1", ov_cnt - ov0); end
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ov_hold got %b/%h exp 1/11", rx_valid, rx_data); end
      fork
         send_frame(8'h22, BIT_115200, 1'b1);
         begin
            repeat (4107) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      #2;
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin errors++; $display("FAIL ov_same_cycle got %b/%h exp 1/22", rx_valid, rx_data); end
      checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ov_none got %0d exp 1", ov_cnt - ov0); end
      rx_ready = 1'b1;
      @(posedge clk); #2;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ov_consume got %b exp 0", rx_valid); end
   endtask

   task automatic test_reset_mid();
      int prev, dt;
      baud_sel = 3'b100; rx_ready = 1'b1;
      fork
         send_frame(8'hF0, BIT_115200, 1'b1);
         begin
            repeat (5 * BIT_115200 + 200) @(posedge clk); #2;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got %b exp 1", busy); end
            rst = 1'b1;
            @(posedge clk); #2;
            checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got busy%b valid%b exp 0 0", busy, rx_valid); end
            checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h exp 00", rx_data); end
            checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b exp 00", frame_err, overrun); end
            repeat (2) @(posedge clk); #1 rst = 1'b0;
         end
      join
      prev = rise_cnt;
      repeat (20) @(posedge clk);
      send_frame(8'hA5, BIT_115200, 1'b1);
      wait_rise(prev, "riseA5");
      dt = rise_cyc - start_cyc;
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL dataA5 got %h exp A5", rx_data); end
      checks++; if (dt < 4104 || dt > 4110) begin errors++; $display("FAIL latA5 got %0d exp 4107+-3", dt); end
   endtask

   initial begin
      test_reset();
      test_timing_55();
      test_baud_change();
      test_frame_err();
      test_glitch();
      test_overrun();
      test_reset_mid();
      checks++; if (drop_cnt != 0) begin errors++; $display("FAIL valid_drop got %0d exp 0", drop_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
